neuron_layer_sequencer: RTL
===========================

// Module: neuron_layer_sequencer
// PURPOSE
// Control FSM that time-shares one layer's MAC datapath (16 parallel accumulators, each 49 steps deep) across NUM_NEURONS neurons.
// Per neuron it clears the accumulators, steps the pixel/weight fetch index through BATCH_SIZE beats and drains the MAC pipeline.
// It then hands the biased sum to the downstream consumer with a valid/ready handshake.
// Sits between the top-level inference controller (start/done) and the accumulator array plus pixel/weight buffers.
// PARAMETERS
// NUM_NEURONS  10  neurons evaluated per layer pass
// BATCH_SIZE   49  beats per neuron (inputs per accumulator lane)
// MAC_LATENCY  3   pipeline depth of one multiply-accumulate lane, in cycles (>=1)
// PORTS
// clk         in   1                     clock, all state on rising edge
// rst         in   1                     synchronous reset, active-low
// start       in   1                     begin a layer pass; sampled only in IDLE
// src_valid   in   1                     pixel/weight beat at step_idx is present on datapath inputs
// res_ready   in   1                     downstream accepts result
// busy        out  1                     pass in progress (state != IDLE)
// step_idx    out  $clog2(BATCH_SIZE)    beat index for pixel/weight buffer read
// neuron_idx  out  $clog2(NUM_NEURONS)   neuron whose weights/bias are selected
// acc_clr     out  1                     clear all accumulator lanes
// acc_en      out  1                     accumulate the current beat in all lanes
// res_valid   out  1                     lane sum + BIAS for neuron_idx is stable at datapath OUT
// layer_done  out  1                     one-cycle pulse: all neurons delivered
// BEHAVIOUR
// - Outputs are registered/Moore-decoded from state. No combinational path from inputs to outputs except acc_en = (state==FEED) & src_valid.
// - rst==0 at any edge, including mid-pass: state=IDLE, step_idx=0, neuron_idx=0, drain_cnt=0. All outputs 0.
// - A pass in flight is abandoned and produces no res_valid or layer_done.
// - States and transitions:
//   - IDLE: start=1 -> CLEAR, neuron_idx=0, step_idx=0. start=0 -> stay.
//   - CLEAR: acc_clr=1 for exactly 1 cycle -> FEED.
//   - FEED: src_valid=1 and step_idx<BATCH_SIZE-1 -> step_idx+1.
//     src_valid=1 and step_idx==BATCH_SIZE-1 -> DRAIN, drain_cnt=0.
//     src_valid=0 -> hold step_idx, acc_en=0 (bubble; no beat lost or duplicated).
//   - DRAIN: acc_en=0, drain_cnt+1 each cycle. drain_cnt==MAC_LATENCY-1 -> RESULT.
//   - RESULT: res_valid=1; neuron_idx/step_idx held stable.
//     res_ready=1 -> (neuron_idx==NUM_NEURONS-1 ? DONE : CLEAR with neuron_idx+1, step_idx=0).
//     res_ready=0 -> stay; res_valid must not drop until accepted.
//   - DONE: layer_done=1 for 1 cycle -> IDLE.
// - start is ignored outside IDLE. start held high through DONE launches a new pass from IDLE on the following edge (IDLE lasts >=1 cycle).
// - res_ready outside RESULT is ignored. res_valid&res_ready in the same cycle = exactly one transfer.
// - Counters never wrap: step_idx stays in 0..BATCH_SIZE-1, neuron_idx in 0..NUM_NEURONS-1. Both reset to 0 in CLEAR/IDLE entry as stated.
// - Latency with src_valid=res_ready=1 throughout: 1+BATCH_SIZE+MAC_LATENCY+1 cycles per neuron. Default = 54.
// - Full pass from the start edge to the layer_done cycle: NUM_NEURONS*54+1 = 541 cycles. busy is high for all 541.
// TESTING
// 1. Reset, start pulse, src_valid=res_ready=1 -> 10 res_valid pulses 54 cycles apart with neuron_idx 0..9. layer_done at cycle 541. busy=0 after.
// 2. src_valid low for 5 cycles at step_idx=20 of neuron 3 -> step_idx holds 20, acc_en=0 for those cycles. Exactly 49 acc_en cycles per neuron. Total 546.
// 3. res_ready low for 7 cycles at neuron 0 RESULT -> res_valid stays 1, neuron_idx=0 stable. Next CLEAR starts the cycle after res_ready rises.
// 4. start pulsed during FEED of neuron 5 -> no effect: neuron_idx sequence unchanged, single layer_done.
// 5. rst=0 during DRAIN of neuron 7 -> next cycle state IDLE, all outputs 0. No layer_done. A fresh start yields a full 10-neuron pass from neuron 0.
// 6. start held high continuously -> back-to-back passes separated by exactly one IDLE cycle after each layer_done.

Source files
------------

// File: rtl/neuron_layer_sequencer.sv
// neuron_layer_sequencer
// Control FSM that time-shares one layer's MAC datapath across NUM_NEURONS
// neurons. For each neuron it clears the accumulators, steps the pixel/weight
// fetch index through BATCH_SIZE beats, and waits MAC_LATENCY cycles for the
// pipeline to drain. It then holds the biased sum valid until downstream
// accepts it. After the last neuron is accepted it emits a one-cycle
// layer_done pulse.
module neuron_layer_sequencer #(
    parameter int NUM_NEURONS = 10,
    parameter int BATCH_SIZE  = 49,
    parameter int MAC_LATENCY = 3,
    localparam int STEP_W = (BATCH_SIZE  > 1) ? $clog2(BATCH_SIZE)  : 1,
    localparam int NEUR_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              src_valid,
    input  logic              res_ready,
    output logic              busy,
    output logic [STEP_W-1:0] step_idx,
    output logic [NEUR_W-1:0] neuron_idx,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              res_valid,
    output logic              layer_done
);

    localparam int DRAIN_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

    localparam logic [STEP_W-1:0]  LAST_STEP   = STEP_W'(BATCH_SIZE - 1);
    localparam logic [STEP_W-1:0]  STEP_ONE    = STEP_W'(1);
    localparam logic [NEUR_W-1:0]  LAST_NEURON = NEUR_W'(NUM_NEURONS - 1);
    localparam logic [NEUR_W-1:0]  NEURON_ONE  = NEUR_W'(1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN  = DRAIN_W'(MAC_LATENCY - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE   = DRAIN_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        RESULT,
        DONE
    } state_t;

    state_t             state;
    logic [DRAIN_W-1:0] drain_cnt;

    // A beat is accumulated only while feeding and the source has data present.
    // A missing beat becomes a bubble, so no beat is lost or duplicated.
    assign acc_en = (state == FEED) && src_valid;

    // Sequencer state, counters and registered status outputs (set on the edge that enters each state)
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            step_idx   <= '0;
            neuron_idx <= '0;
            drain_cnt  <= '0;
            busy       <= 1'b0;
            acc_clr    <= 1'b0;
            res_valid  <= 1'b0;
            layer_done <= 1'b0;
        end else begin
            acc_clr    <= 1'b0;
            layer_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= CLEAR;
                        step_idx   <= '0;
                        neuron_idx <= '0;
                        busy       <= 1'b1;
                        acc_clr    <= 1'b1;
                    end
                end
                CLEAR: begin
                    state <= FEED;
                end
                FEED: begin
                    if (src_valid) begin
                        if (step_idx == LAST_STEP) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            step_idx <= step_idx + STEP_ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == LAST_DRAIN) begin
                        state     <= RESULT;
                        res_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_ONE;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (neuron_idx == LAST_NEURON) begin
                            state      <= DONE;
                            layer_done <= 1'b1;
                        end else begin
                            state      <= CLEAR;
                            neuron_idx <= neuron_idx + NEURON_ONE;
                            step_idx   <= '0;
                            acc_clr    <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    res_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule
